alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 64-bit ALU (ports A, B, ALUOp, result) between two requesters: requester 0 is the execute stage, requester 1 is branch/address generation.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. Operands are registered into the ALU, and the result is registered back out.
- Sits between the pipeline control and the combinational ALU.

Parameters:
WIDTH, 64, operand/result width
OPW, 4, ALU opcode width (matches ALUOp)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  operand A, requester 0
req0_b  in  WIDTH  operand B, requester 0
req0_op  in  OPW  ALU opcode, requester 0
resp0_valid  out  1  result available for requester 0
resp0_ready  in  1  requester 0 consumes result
resp0_result  out  WIDTH  result for requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_op, resp1_valid, resp1_ready, resp1_result: same as requester 0, for requester 1
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_op  out  OPW  to ALU ALUOp
alu_result  in  WIDTH  from ALU result (combinational)
busy  out  1  state != IDLE

Behaviour:
- Clock, reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state=IDLE, prio=0, owner=0.
  - alu_a=0, alu_b=0, alu_op=0.
  - result register=0.
  - resp0_valid=resp1_valid=0, busy=0.
- States: IDLE, EXEC, RESP.
- IDLE, grant (combinational):
  - Both valid: grant = prio.
  - Only one valid: grant = that requester.
  - None valid: no grant.
  - reqX_ready=1 only for the granted requester, and only in IDLE. reqX_ready depends on reqX_valid.
- IDLE, on accept (valid && ready):
  - Register the granted requester's a/b/op into alu_a/alu_b/alu_op.
  - owner <= grant; prio <= ~grant.
  - Go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op stay stable.
  - At cycle end, result register <= alu_result; go to RESP.
- RESP:
  - resp<owner>_valid=1; resp<owner>_result = result register; the other resp valid = 0.
  - Hold until resp<owner>_ready=1, then go to IDLE.
  - respX_result of the non-owner is don't-care; the implementation drives the result register onto both.
- Latency: accept at edge N, resp_valid high in cycle N+2. Minimum 3 cycles per operation.
- No accept in the same cycle a response completes. IDLE is always visited between operations.
- alu_a/alu_b/alu_op hold their last values outside EXEC; they never return to 0 except on reset.
- Fairness: back-to-back contention alternates 0,1,0,1. A lone requester is served repeatedly, with prio flipping after each grant.
- Valid rules:
  - A requester deasserting valid before ready is permitted; nothing is latched.
  - Operand changes while not ready are ignored.
- Reset mid-operation (EXEC or RESP): in-flight operation discarded, both resp valids drop to 0 asynchronously, prio returns to 0.
- resp_ready asserted by the non-owner or outside RESP: ignored.

Test Plan:
- Bench ALU stub: alu_result = alu_a + alu_b for op 4'b0010.
- Single op: req0 valid, a=10, b=10, op=0010, resp0_ready=1 → req0_ready in cycle 0; alu_op=0010 in cycle 1; resp0_valid with 20 in cycle 2; busy low in cycle 3.
- Contention from reset: both valid; req0 (30,10) and req1 (5,7) → req0 served first (result 40), req1 second (result 12); resp1_valid never high during req0's op.
- Alternation: both requesters hold valid for 4 ops → grant order 0,1,0,1; each op takes 3 cycles.
- Backpressure: resp1_ready held 0 for 5 cycles → resp1_valid and resp1_result stay stable; req0_ready stays 0 throughout; op completes the cycle after resp1_ready=1.
- Reset mid-op: assert rst_n=0 in EXEC → resp valids 0 and alu_a/alu_b/alu_op=0 immediately; after release, a new req1 op completes normally with prio=0 semantics.
- Hold check: after an op with a=0x3FFC, b=0x7, alu_a/alu_b stay 0x3FFC/0x7 in IDLE until the next accept.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (0)
// and branch/address generation (1); operands and result are both registered.
module alu_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_prio;
  logic             r_owner;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_result;
  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic             w_owner_ready;

  // Under contention prio picks the winner; otherwise the lone valid requester wins.
  always_comb begin
    w_idle     = (r_state == StIdle);
    w_grant    = (req0_valid && req1_valid) ? r_prio : req1_valid;
    req0_ready = w_idle && req0_valid && !w_grant;
    req1_ready = w_idle && req1_valid && w_grant;
    w_accept   = req0_ready || req1_ready;
  end

  always_comb begin
    w_owner_ready = r_owner ? resp1_ready : resp0_ready;
    w_state_next  = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StExec;
      StExec:  w_state_next = StResp;
      StResp:  if (w_owner_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_owner <= w_grant;
        r_prio  <= ~w_grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= w_grant ? req1_a  : req0_a;
        r_alu_b  <= w_grant ? req1_b  : req0_b;
        r_alu_op <= w_grant ? req1_op : req0_op;
      end
      if (r_state == StExec) r_result <= alu_result;
    end
  end

  always_comb begin
    alu_a        = r_alu_a;
    alu_b        = r_alu_b;
    alu_op       = r_alu_op;
    resp0_valid  = (r_state == StResp) && !r_owner;
    resp1_valid  = (r_state == StResp) && r_owner;
    resp0_result = r_result;
    resp1_result = r_result;
    busy         = !w_idle;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic [63:0] req0_a, req0_b, resp0_result;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [63:0] req1_a, req1_b, resp1_result;
  logic [3:0]  req1_op;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit m_prio   = 1'b0;

  alu_arbiter #(.WIDTH(64), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .busy(busy)
  );

  function automatic logic [63:0] alu_fn(input logic [63:0] a, b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE; owner's resp_ready held low for 'stall' RESP cycles.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] op0,
                        input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] op1,
                        input int stall);
    bit          g;
    logic [63:0] ea, eb, er;
    logic [3:0]  eop;
    @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    #1;
    g   = (v0 && v1) ? m_prio : v1;
    ea  = g ? a1 : a0;
    eb  = g ? b1 : b0;
    eop = g ? op1 : op0;
    er  = alu_fn(ea, eb, eop);
    chk("idle_busy", busy, 0);
    chk("idle_req0_ready", req0_ready, v0 && !g);
    chk("idle_req1_ready", req1_ready, v1 && g);
    m_prio = !g;
    @(negedge clk);
    req0_valid = 1'($urandom); req0_a = {$urandom, $urandom}; req0_op = 4'($urandom);
    req1_valid = 1'($urandom); req1_b = {$urandom, $urandom}; req1_op = 4'($urandom);
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_op", alu_op, eop);
    chk("exec_ready", {req0_ready, req1_ready}, 0);
    chk("exec_resp_valid", {resp0_valid, resp1_valid}, 0);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      resp0_ready = g ? 1'b1 : (i == stall);
      resp1_ready = g ? (i == stall) : 1'b1;
      #1;
      chk("resp_resp0_valid", resp0_valid, !g);
      chk("resp_resp1_valid", resp1_valid, g);
      chk("resp_result", g ? resp1_result : resp0_result, er);
      chk("resp_req_ready", {req0_ready, req1_ready}, 0);
      chk("resp_busy", busy, 1);
    end
  endtask

  initial begin
    bit          v0, v1;
    logic [3:0]  ops [5];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; resp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; resp1_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_alu", {alu_a, alu_b} != 0, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_result", resp0_result, 0);
    chk("rst_valid_busy", {resp0_valid, resp1_valid, busy}, 0);
    rst_n = 1'b1;

    // single op, contention, alternation
    run_op(1, 0, 64'd10, 64'd10, 4'b0010, 0, 0, 0, 0);
    run_op(1, 1, 64'd30, 64'd10, 4'b0010, 64'd5, 64'd7, 4'b0010, 0);
    run_op(1, 1, 64'd30, 64'd10, 4'b0010, 64'd5, 64'd7, 4'b0010, 0);
    for (int k = 0; k < 4; k++)
      run_op(1, 1, 64'(k), 64'd100, 4'b0010, 64'(k + 50), 64'd200, 4'b0110, 0);
    // lone requester served repeatedly
    run_op(0, 1, 0, 0, 0, 64'd1, 64'd2, 4'b0010, 0);
    run_op(0, 1, 0, 0, 0, 64'd3, 64'd4, 4'b0010, 0);
    // backpressure on requester 1
    run_op(1, 1, 64'd9, 64'd9, 4'b0010, 64'hABCD, 64'h1111, 4'b0010, 5);
    run_op(1, 1, 64'd9, 64'd9, 4'b0010, 64'hABCD, 64'h1111, 4'b0010, 5);

    // operands hold in IDLE
    run_op(1, 0, 64'h3FFC, 64'h7, 4'b0010, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
      #1;
      chk("hold_alu_a", alu_a, 64'h3FFC);
      chk("hold_alu_b", alu_b, 64'h7);
      chk("hold_busy", busy, 0);
    end

    // reset during EXEC of a req0 op (prio would have become 1)
    @(negedge clk);
    req0_valid = 1; req0_a = 64'h55; req0_b = 64'h66; req0_op = 4'b0010;
    @(negedge clk);
    req0_valid = 0;
    chk("abort_in_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", {resp0_valid, resp1_valid}, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_op", alu_op, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_prio = 1'b0;
    run_op(1, 1, 64'd1, 64'd1, 4'b0010, 64'd2, 64'd2, 4'b0010, 0);
    run_op(0, 1, 0, 0, 0, 64'd40, 64'd2, 4'b0010, 1);

    for (int k = 0; k < 40; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      run_op(v0, v1, {$urandom, $urandom}, {$urandom, $urandom}, ops[$urandom_range(0, 4)],
             {$urandom, $urandom}, {$urandom, $urandom}, ops[$urandom_range(0, 4)],
             int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    #1;
    chk("final_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
